// File: rtl/alu_pkg.sv
// Shared constants for the R-type ALU driver: opcode/funct codes, FSM states
// and the decode rule that decides whether an instruction word is executable.
package alu_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;

   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_SLL = 6'b000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2,
      ERR  = 2'd3
   } state_t;

   function automatic logic instr_is_legal(input logic [31:0] word);
      logic [5:0] funct;
      funct = word[5:0];
      return (word[31:26] == OP_RTYPE) &&
             ((funct == FUNCT_AND) || (funct == FUNCT_OR)  ||
              (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
              (funct == FUNCT_SLT) || (funct == FUNCT_SLL));
   endfunction

endpackage

// File: rtl/alu_driver_if.sv
// Bundle of the driver's instruction, preload, ALU, writeback and debug signals.
// slave = the driver itself; master = whoever feeds it and hosts the ALU.
interface alu_driver_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        ld_en;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic [31:0] alu_dataA;
   logic [31:0] alu_dataB;
   logic [5:0]  alu_Signal;
   logic [31:0] alu_dataOut;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   modport slave (
      input  instr_valid, instr, ld_en, ld_addr, ld_data, alu_dataOut, dbg_addr,
      output instr_ready, alu_dataA, alu_dataB, alu_Signal,
             wb_valid, wb_rd, wb_data, illegal, dbg_data
   );

   modport master (
      output instr_valid, instr, ld_en, ld_addr, ld_data, alu_dataOut, dbg_addr,
      input  instr_ready, alu_dataA, alu_dataB, alu_Signal,
             wb_valid, wb_rd, wb_data, illegal, dbg_data
   );
endinterface

// File: rtl/alu_regfile.sv
// 32x32 register file: two combinational operand reads, one debug read,
// one synchronous write; register 0 is hard-wired to zero.
module alu_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_raddr_a,
   input  logic [4:0]  i_raddr_b,
   input  logic [4:0]  i_dbg_addr,
   output logic [31:0] o_rdata_a,
   output logic [31:0] o_rdata_b,
   output logic [31:0] o_dbg_data
);
   logic [31:0] w_regs [32];

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign w_regs[gi] = '0;
         end else begin : g_word
            logic [31:0] r_q;
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  r_q <= '0;
               end else if (i_we && (i_waddr == 5'(gi))) begin
                  r_q <= i_wdata;
               end
            end
            assign w_regs[gi] = r_q;
         end
      end
   endgenerate

   assign o_rdata_a  = w_regs[i_raddr_a];
   assign o_rdata_b  = w_regs[i_raddr_b];
   assign o_dbg_data = w_regs[i_dbg_addr];
endmodule

// File: rtl/alu_driver.sv
// Sequences one R-type instruction at a time through an external combinational
// ALU: latch operands, wait ALU_LAT cycles, write back, report.
module alu_driver
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   alu_driver_if.slave bus
);
   localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_lat_cnt;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [5:0]  r_alu_sig;
   logic [4:0]  r_rd;
   logic [31:0] r_wb_data;
   logic [4:0]  r_wb_rd;

   logic        w_ready;
   logic        w_accept;
   logic        w_legal;
   logic        w_done;
   logic        w_wb_valid;
   logic        w_illegal;
   logic        w_we;
   logic [4:0]  w_waddr;
   logic [31:0] w_wdata;
   logic [31:0] w_rs_data;
   logic [31:0] w_rt_data;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_shamt;
   logic [5:0]  w_funct;

   assign w_rs    = bus.instr[25:21];
   assign w_rt    = bus.instr[20:16];
   assign w_rd    = bus.instr[15:11];
   assign w_shamt = bus.instr[10:6];
   assign w_funct = bus.instr[5:0];

   assign w_legal  = instr_is_legal(bus.instr);
   assign w_accept = w_ready && bus.instr_valid;
   assign w_done   = (r_state == EXEC) && (r_lat_cnt == LAT_LAST);

   // The writeback and the preload share the single write port; they can
   // never collide because preload is only honoured in IDLE.
   assign w_we    = w_done || ((r_state == IDLE) && bus.ld_en);
   assign w_waddr = w_done ? r_rd : bus.ld_addr;
   assign w_wdata = w_done ? bus.alu_dataOut : bus.ld_data;

   alu_regfile u_regfile (
      .clk        (clk),
      .reset      (reset),
      .i_we       (w_we),
      .i_waddr    (w_waddr),
      .i_wdata    (w_wdata),
      .i_raddr_a  (w_rs),
      .i_raddr_b  (w_rt),
      .i_dbg_addr (bus.dbg_addr),
      .o_rdata_a  (w_rs_data),
      .o_rdata_b  (w_rt_data),
      .o_dbg_data (bus.dbg_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Ready is also gated by reset so nothing looks acceptable while held.
   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_wb_valid   = 1'b0;
      w_illegal    = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_ready = reset && !bus.ld_en;
            if (w_ready && bus.instr_valid) begin
               w_state_next = w_legal ? EXEC : ERR;
            end
         end
         EXEC: begin
            if (w_done) begin
               w_state_next = WB;
            end
         end
         WB: begin
            w_wb_valid   = 1'b1;
            w_state_next = IDLE;
         end
         ERR: begin
            w_illegal    = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lat_cnt <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sig <= '0;
         r_rd      <= '0;
         r_wb_data <= '0;
         r_wb_rd   <= '0;
      end else begin
         if (w_accept && w_legal) begin
            r_alu_sig <= w_funct;
            r_rd      <= w_rd;
            r_lat_cnt <= '0;
            if (w_funct == FUNCT_SLL) begin
               r_alu_a <= w_rt_data;
               r_alu_b <= {27'b0, w_shamt};
            end else begin
               r_alu_a <= w_rs_data;
               r_alu_b <= w_rt_data;
            end
         end else if ((r_state == EXEC) && !w_done) begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
         end
         if (w_done) begin
            r_wb_data <= bus.alu_dataOut;
            r_wb_rd   <= r_rd;
         end
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.wb_valid    = w_wb_valid;
   assign bus.illegal     = w_illegal;
   assign bus.wb_data     = r_wb_data;
   assign bus.wb_rd       = r_wb_rd;
   assign bus.alu_dataA   = r_alu_a;
   assign bus.alu_dataB   = r_alu_b;
   assign bus.alu_Signal  = r_alu_sig;
endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: hosts the external ALU, keeps a register
// model of the architectural state and compares every reported result.
module tb_alu_driver;
   import alu_pkg::*;

   localparam int LAT = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   alu_driver_if bus ();

   alu_driver #(.ALU_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // The external 32-bit ALU: shift amount arrives on dataB, value on dataA.
   function automatic logic [31:0] ext_alu(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         FUNCT_AND: return a & b;
         FUNCT_OR:  return a | b;
         FUNCT_ADD: return a + b;
         FUNCT_SUB: return a - b;
         FUNCT_SLT: return {31'b0, ($signed(a) < $signed(b))};
         FUNCT_SLL: return a << b[4:0];
         default:   return 32'h0;
      endcase
   endfunction
   assign bus.alu_dataOut = ext_alu(bus.alu_Signal, bus.alu_dataA, bus.alu_dataB);

   int checks = 0;
   int errors = 0;
   logic [31:0] ref_r [32];

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk_r(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
      return {6'b0, rs, rt, rd, sh, f};
   endfunction

   function automatic bit ref_legal(input logic [31:0] w);
      int lf [6];
      lf = '{36, 37, 32, 34, 42, 0};
      if (w[31:26] != 6'd0) return 1'b0;
      foreach (lf[i]) if (int'(w[5:0]) == lf[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_value(input logic [31:0] w);
      logic [31:0] x;
      logic [31:0] y;
      x = ref_r[w[25:21]];
      y = ref_r[w[20:16]];
      case (int'(w[5:0]))
         36:      return x & y;
         37:      return x | y;
         32:      return x + y;
         34:      return x - y;
         42:      return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         0:       return y << w[10:6];
         default: return 32'h0;
      endcase
   endfunction

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
      @(negedge clk);
      bus.ld_en = 1'b0;
      if (a != 5'd0) ref_r[a] = d;
   endtask

   task automatic read_dbg(input logic [4:0] a, output logic [31:0] d);
      bus.dbg_addr = a;
      #1;
      d = bus.dbg_data;
   endtask

   // Issues one word and observes the LAT+2 cycles that follow the accept edge.
   task automatic do_instr(input logic [31:0] w, output int wb_cnt, output int wb_k, output int ill_cnt,
                           output int ready_k, output logic [31:0] wbd, output logic [4:0] wbr,
                           output logic [5:0] sig, output logic [31:0] a, output logic [31:0] b,
                           output bit stable);
      int waitc;
      wb_cnt = 0; wb_k = 0; ill_cnt = 0; ready_k = 0; wbd = '0; wbr = '0;
      sig = '0; a = '0; b = '0; stable = 1'b1; waitc = 0;
      @(negedge clk);
      bus.instr = w; bus.instr_valid = 1'b1;
      while (!bus.instr_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      checks++;
      if (!bus.instr_ready) begin
         errors++;
         $display("FAIL accept_timeout instr=%08h ready=%0b want 1", w, bus.instr_ready);
         bus.instr_valid = 1'b0;
      end else begin
         @(posedge clk);
         for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
               bus.instr_valid = 1'b0;
               sig = bus.alu_Signal; a = bus.alu_dataA; b = bus.alu_dataB;
            end else if (sig !== bus.alu_Signal || a !== bus.alu_dataA || b !== bus.alu_dataB) begin
               stable = 1'b0;
            end
            if (wb_cnt > 0 && (bus.wb_data !== wbd || bus.wb_rd !== wbr)) stable = 1'b0;
            if (bus.wb_valid) begin
               wb_cnt++; wb_k = k; wbd = bus.wb_data; wbr = bus.wb_rd;
            end
            if (bus.illegal) ill_cnt++;
            if (bus.instr_ready && ready_k == 0) ready_k = k;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0;
      bus.instr_valid = 1'b0; bus.instr = '0; bus.ld_en = 1'b0;
      bus.ld_addr = '0; bus.ld_data = '0; bus.dbg_addr = '0;
      foreach (ref_r[i]) ref_r[i] = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.instr_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %0b want 0", bus.instr_ready);
      end
      checks++;
      if ({bus.wb_valid, bus.illegal, bus.alu_Signal} !== 8'h0) begin
         errors++; $display("FAIL reset_flags got wb=%0b ill=%0b sig=%0h want 0", bus.wb_valid, bus.illegal, bus.alu_Signal);
      end
      checks++;
      if ({bus.alu_dataA, bus.alu_dataB, bus.wb_data, bus.wb_rd} !== '0) begin
         errors++; $display("FAIL reset_data got A=%08h B=%08h wbd=%08h wbrd=%0d want 0", bus.alu_dataA, bus.alu_dataB, bus.wb_data, bus.wb_rd);
      end
      read_dbg(5'd9, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL reset_reg got %08h want 0", d);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.instr_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready got %0b want 1", bus.instr_ready);
      end
   endtask

   task automatic test_add();
      int wc, wk, ic, rk; logic [31:0] wd, a, b, d; logic [4:0] wr; logic [5:0] s; bit st;
      @(negedge clk);
      bus.ld_en = 1'b1; bus.ld_addr = 5'd1; bus.ld_data = 32'd5;
      #1;
      checks++;
      if (bus.instr_ready !== 1'b0) begin
         errors++; $display("FAIL preload_blocks_ready got %0b want 0", bus.instr_ready);
      end
      @(negedge clk);
      bus.ld_en = 1'b0; ref_r[1] = 32'd5;
      preload(5'd2, 32'd3);
      do_instr(mk_r(6'd32, 5'd1, 5'd2, 5'd3, 5'd0), wc, wk, ic, rk, wd, wr, s, a, b, st);
      checks++;
      if (wc != 1 || wk != LAT + 1) begin
         errors++; $display("FAIL add_wb_timing got count=%0d cycle=%0d want 1 %0d", wc, wk, LAT + 1);
      end
      checks++;
      if (wd !== 32'd8 || wr !== 5'd3) begin
         errors++; $display("FAIL add_wb_data got %0d rd=%0d want 8 rd=3", wd, wr);
      end
      checks++;
      if (s !== 6'd32 || a !== 32'd5 || b !== 32'd3) begin
         errors++; $display("FAIL add_operands got sig=%0d A=%0d B=%0d want 32 5 3", s, a, b);
      end
      checks++;
      if (rk != LAT + 2 || !st || ic != 0) begin
         errors++; $display("FAIL add_ready_hold got ready_k=%0d stable=%0b ill=%0d want %0d 1 0", rk, st, ic, LAT + 2);
      end
      read_dbg(5'd3, d);
      checks++;
      if (d !== 32'd8) begin
         errors++; $display("FAIL add_dbg_r3 got %0d want 8", d);
      end
      ref_r[3] = 32'd8;
   endtask

   task automatic test_sub_slt();
      int wc, wk, ic, rk; logic [31:0] wd, a, b, d; logic [4:0] wr; logic [5:0] s; bit st;
      preload(5'd1, 32'd3);
      preload(5'd2, 32'd5);
      do_instr(mk_r(6'd34, 5'd1, 5'd2, 5'd4, 5'd0), wc, wk, ic, rk, wd, wr, s, a, b, st);
      checks++;
      if (wc != 1 || wd !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL sub_wb got count=%0d data=%08h want 1 fffffffe", wc, wd);
      end
      ref_r[4] = 32'hFFFF_FFFE;
      do_instr(mk_r(6'd42, 5'd1, 5'd2, 5'd5, 5'd0), wc, wk, ic, rk, wd, wr, s, a, b, st);
      checks++;
      if (wc != 1 || wd !== 32'd1) begin
         errors++; $display("FAIL slt_wb got count=%0d data=%08h want 1 1", wc, wd);
      end
      ref_r[5] = 32'd1;
      read_dbg(5'd4, d);
      checks++;
      if (d !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL sub_dbg_r4 got %08h want fffffffe", d);
      end
      read_dbg(5'd5, d);
      checks++;
      if (d !== 32'd1) begin
         errors++; $display("FAIL slt_dbg_r5 got %08h want 1", d);
      end
   endtask

   task automatic test_illegal();
      int wc, wk, ic, rk; logic [31:0] wd, a, b, d; logic [4:0] wr; logic [5:0] s; bit st;
      logic [31:0] words [2];
      int bad;
      words[0] = {6'h23, 5'd1, 5'd2, 5'd7, 5'd0, 6'd32};
      words[1] = mk_r(6'h27, 5'd1, 5'd2, 5'd7, 5'd0);
      foreach (words[i]) begin
         do_instr(words[i], wc, wk, ic, rk, wd, wr, s, a, b, st);
         checks++;
         if (ic != 1 || wc != 0 || rk != 2) begin
            errors++; $display("FAIL illegal_%0d got ill=%0d wb=%0d ready_k=%0d want 1 0 2", i, ic, wc, rk);
         end
      end
      bad = 0;
      for (int r = 0; r < 32; r++) begin
         read_dbg(5'(r), d);
         if (d !== ref_r[r]) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL illegal_regs_changed got %0d differing want 0", bad);
      end
   endtask

   task automatic test_rd0();
      int wc, wk, ic, rk; logic [31:0] wd, a, b, d; logic [4:0] wr; logic [5:0] s; bit st;
      preload(5'd1, 32'd5);
      preload(5'd2, 32'd3);
      do_instr(mk_r(6'd32, 5'd1, 5'd2, 5'd0, 5'd0), wc, wk, ic, rk, wd, wr, s, a, b, st);
      checks++;
      if (wc != 1 || wd !== 32'd8 || wr !== 5'd0) begin
         errors++; $display("FAIL rd0_wb got count=%0d data=%0d rd=%0d want 1 8 0", wc, wd, wr);
      end
      read_dbg(5'd0, d);
      checks++;
      if (d !== 32'd0) begin
         errors++; $display("FAIL rd0_dbg got %08h want 0", d);
      end
   endtask

   task automatic test_sll();
      int wc, wk, ic, rk; logic [31:0] wd, a, b, v, exp; logic [4:0] wr, sh; logic [5:0] s; bit st;
      logic [31:0] w;
      for (int n = 0; n < 3; n++) begin
         v  = $urandom;
         sh = 5'($urandom_range(0, 31));
         preload(5'd7, v);
         w = mk_r(6'd0, 5'($urandom_range(0, 31)), 5'd7, 5'd8, sh);
         exp = ref_value(w);
         do_instr(w, wc, wk, ic, rk, wd, wr, s, a, b, st);
         checks++;
         if (wc != 1 || wd !== exp || a !== v || b !== {27'b0, sh}) begin
            errors++; $display("FAIL sll got data=%08h A=%08h B=%0d want %08h %08h %0d", wd, a, b, exp, v, sh);
         end
         ref_r[8] = exp;
      end
   endtask

   task automatic test_random();
      int wc, wk, ic, rk; logic [31:0] wd, a, b, d, w, exp; logic [4:0] wr; logic [5:0] s; bit st, lg;
      int lf [6];
      int bad;
      lf = '{36, 37, 32, 34, 42, 0};
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) preload(5'($urandom_range(0, 31)), $urandom);
         w = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            w[31:26] = 6'd0;
            w[5:0]   = 6'(lf[$urandom_range(0, 5)]);
         end else if ($urandom_range(0, 1) == 0) begin
            w[31:26] = 6'($urandom_range(1, 63));
         end else begin
            w[31:26] = 6'd0;
            while (ref_legal(w)) w[5:0] = 6'($urandom);
         end
         lg  = ref_legal(w);
         exp = ref_value(w);
         do_instr(w, wc, wk, ic, rk, wd, wr, s, a, b, st);
         checks++;
         if (lg && (wc != 1 || wk != LAT + 1 || wd !== exp || wr !== w[15:11] || ic != 0 || !st || rk != LAT + 2)) begin
            errors++; $display("FAIL rand_exec instr=%08h got count=%0d cyc=%0d data=%08h rd=%0d ill=%0d stable=%0b want 1 %0d %08h %0d 0 1",
                               w, wc, wk, wd, wr, ic, st, LAT + 1, exp, w[15:11]);
         end else if (!lg && (ic != 1 || wc != 0 || rk != 2)) begin
            errors++; $display("FAIL rand_illegal instr=%08h got ill=%0d wb=%0d ready_k=%0d want 1 0 2", w, ic, wc, rk);
         end
         if (lg && w[15:11] != 5'd0) ref_r[w[15:11]] = exp;
      end
      bad = 0;
      for (int r = 0; r < 32; r++) begin
         read_dbg(5'(r), d);
         if (d !== ref_r[r]) begin
            bad++; $display("FAIL rand_reg r%0d got %08h want %08h", r, d, ref_r[r]);
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   task automatic test_reset_exec();
      int waitc, wbseen; logic [31:0] d;
      preload(5'd6, 32'h0000_1234);
      preload(5'd1, 32'hF0F0_0000);
      preload(5'd2, 32'h0000_000F);
      @(negedge clk);
      bus.instr = mk_r(6'd37, 5'd1, 5'd2, 5'd6, 5'd0); bus.instr_valid = 1'b1;
      waitc = 0;
      while (!bus.instr_ready && waitc < 50) begin
         @(negedge clk); waitc++;
      end
      @(posedge clk);
      wbseen = 0;
      for (int k = 1; k < LAT; k++) begin
         @(negedge clk);
         bus.instr_valid = 1'b0;
         if (bus.wb_valid) wbseen++;
      end
      @(negedge clk);
      bus.instr_valid = 1'b0;
      reset = 1'b0;
      foreach (ref_r[i]) ref_r[i] = '0;
      repeat (2) begin
         @(negedge clk);
         if (bus.wb_valid) wbseen++;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.instr_ready !== 1'b1) begin
         errors++; $display("FAIL abort_release_ready got %0b want 1", bus.instr_ready);
      end
      repeat (LAT + 2) begin
         @(negedge clk);
         if (bus.wb_valid) wbseen++;
      end
      checks++;
      if (wbseen != 0) begin
         errors++; $display("FAIL abort_wb_valid got %0d pulses want 0", wbseen);
      end
      read_dbg(5'd6, d);
      checks++;
      if (d !== ref_r[6]) begin
         errors++; $display("FAIL abort_r6 got %08h want %08h", d, ref_r[6]);
      end
   endtask

   task automatic test_back_to_back();
      int acc, low_run, nwb;
      logic [31:0] exp;
      preload(5'd1, 32'd1);
      @(negedge clk);
      bus.instr = mk_r(6'd32, 5'd1, 5'd1, 5'd1, 5'd0);
      bus.instr_valid = 1'b1;
      acc = 0; low_run = 0; nwb = 0; exp = 32'd2;
      #1;
      for (int n = 0; n < 12 * (LAT + 2) && !(acc == 4 && nwb == 3); n++) begin
         if (n > 0) @(negedge clk);
         if (bus.wb_valid) begin
            checks++;
            if (bus.wb_data !== exp) begin
               errors++; $display("FAIL b2b_value_%0d got %0d want %0d", nwb, bus.wb_data, exp);
            end
            exp = exp << 1; nwb++;
         end
         if (bus.instr_ready) begin
            if (acc > 0) begin
               checks++;
               if (low_run != LAT + 1) begin
                  errors++; $display("FAIL b2b_gap_%0d got %0d want %0d", acc, low_run, LAT + 1);
               end
            end
            low_run = 0; acc++;
            if (acc == 4) bus.instr_valid = 1'b0;
         end else begin
            low_run++;
         end
      end
      bus.instr_valid = 1'b0;
      checks++;
      if (nwb != 3 || acc != 4) begin
         errors++; $display("FAIL b2b_count got wb=%0d ready=%0d want 3 4", nwb, acc);
      end
      ref_r[1] = 32'd8;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_slt();
      test_illegal();
      test_rd0();
      test_sll();
      test_back_to_back();
      test_random();
      test_reset_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
